// File: rtl/fpu_8097_csr_stack_responder.sv
// CSR responder owning the 8097 64-bit operand stack; the engine port has priority over CSR traffic.
// Optional PEEK_LO/PEEK_HI access is enabled with the FPU8097_STACK_PEEK_EN macro.
module fpu_8097_csr_stack_responder #(
  parameter int          DEPTH     = 8,
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter logic [1:0]  PRIV_MIN  = 2'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       csr_req_valid,
  output logic                       csr_req_ready,
  input  logic                       csr_req_write,
  input  logic [11:0]                csr_req_addr,
  input  logic [31:0]                csr_req_wdata,
  input  logic [3:0]                 csr_req_wstrb,
  input  logic [1:0]                 csr_req_priv,
  output logic                       csr_rsp_valid,
  output logic [31:0]                csr_rsp_rdata,
  output logic                       csr_rsp_fault,
  input  logic                       busy_i,
  input  logic                       eng_valid,
  input  logic [1:0]                 eng_pop,
  input  logic                       eng_push,
  input  logic [63:0]                eng_data,
  output logic                       eng_ack,
  output logic [63:0]                tos_o,
  output logic [63:0]                nos_o,
  output logic [$clog2(DEPTH):0]     depth_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [11:0] OFF_STATUS  = 12'h000;
  localparam logic [11:0] OFF_PUSH_LO = 12'h004;
  localparam logic [11:0] OFF_PUSH_HI = 12'h008;
  localparam logic [11:0] OFF_POP_LO  = 12'h00C;
  localparam logic [11:0] OFF_POP_HI  = 12'h010;
`ifdef FPU8097_STACK_PEEK_EN
  localparam logic [11:0] OFF_PEEK_LO = 12'h014;
  localparam logic [11:0] OFF_PEEK_HI = 12'h018;
`endif

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_fault_q, rsp_fault_d;
  logic           eng_ack_q, eng_ack_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [AW-1:0]  top_q, top_d;
  logic [31:0]    pop_hi_latch_q, pop_hi_latch_d;
  logic [31:0]    push_lo_stage_q, push_lo_stage_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [63:0]    mem_q [DEPTH];

  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [63:0]    mem_wdata;
  logic [DW-1:0]  eng_depth;
  logic [AW-1:0]  eng_top;
  logic [AW-1:0]  nos_idx;
  logic [11:0]    off;
  logic           in_win, csr_hs, full, empty, flt;
  logic [31:0]    rd, status;
  logic [63:0]    tos;

  assign full          = (depth_q == DW'(DEPTH));
  assign empty         = (depth_q == '0);
  assign nos_idx       = top_q - AW'(1);
  assign tos           = mem_q[top_q];
  assign tos_o         = empty ? 64'h0 : tos;
  assign nos_o         = (depth_q >= DW'(2)) ? mem_q[nos_idx] : 64'h0;
  assign depth_o       = depth_q;
  assign csr_req_ready = (state_q == S_IDLE) && !eng_valid;
  assign csr_hs        = csr_req_valid && csr_req_ready;
  assign off           = csr_req_addr - BASE_ADDR;
  assign in_win        = (csr_req_addr >= BASE_ADDR) && (off <= 12'h018) && (off[1:0] == 2'b00);
  assign csr_rsp_valid = rsp_valid_q;
  assign csr_rsp_rdata = rsp_rdata_q;
  assign csr_rsp_fault = rsp_fault_q;
  assign eng_ack       = eng_ack_q;

  always_comb begin
    status        = 32'h0;
    status[0]     = busy_i;
    status[8:4]   = 5'(depth_q);
    status[9]     = full;
    status[10]    = empty;
    status[11]    = ovf_q;
    status[12]    = unf_q;
  end

  always_comb begin
    state_d         = S_IDLE;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = 32'h0;
    rsp_fault_d     = 1'b0;
    eng_ack_d       = 1'b0;
    depth_d         = depth_q;
    top_d           = top_q;
    pop_hi_latch_d  = pop_hi_latch_q;
    push_lo_stage_d = push_lo_stage_q;
    ovf_d           = ovf_q;
    unf_d           = unf_q;
    mem_we          = 1'b0;
    mem_waddr       = top_q + AW'(1);
    mem_wdata       = eng_data;
    eng_depth       = depth_q;
    eng_top         = top_q;
    rd              = 32'h0;
    flt             = 1'b0;

    // Engine update: pops first (clamped at empty), then the optional push.
    if (eng_valid) begin
      eng_ack_d = 1'b1;
      if (DW'(eng_pop) > depth_q) begin
        eng_depth = '0;
        eng_top   = top_q - AW'(depth_q);
        unf_d     = 1'b1;
      end else begin
        eng_depth = depth_q - DW'(eng_pop);
        eng_top   = top_q - AW'(eng_pop);
      end
      depth_d = eng_depth;
      top_d   = eng_top;
      if (eng_push) begin
        if (eng_depth == DW'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = eng_top + AW'(1);
          top_d     = eng_top + AW'(1);
          depth_d   = eng_depth + DW'(1);
        end
      end
    end

    // CSR access: decoded and committed on the handshake, answered next cycle.
    if (csr_hs) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      if ((csr_req_priv < PRIV_MIN) || !in_win) begin
        flt = 1'b1;
      end else begin
        case (off)
          OFF_STATUS: begin
            if (csr_req_write) begin
              if (csr_req_wstrb[1]) begin
                if (csr_req_wdata[11]) ovf_d = 1'b0;
                if (csr_req_wdata[12]) unf_d = 1'b0;
              end
            end else begin
              rd = status;
            end
          end
          OFF_PUSH_LO: begin
            if (!csr_req_write || csr_req_wstrb != 4'hF) flt = 1'b1;
            else push_lo_stage_d = csr_req_wdata;
          end
          OFF_PUSH_HI: begin
            if (!csr_req_write || csr_req_wstrb != 4'hF) begin
              flt = 1'b1;
            end else if (full) begin
              flt   = 1'b1;
              ovf_d = 1'b1;
            end else begin
              mem_we          = 1'b1;
              mem_waddr       = top_q + AW'(1);
              mem_wdata       = {csr_req_wdata, push_lo_stage_q};
              top_d           = top_q + AW'(1);
              depth_d         = depth_q + DW'(1);
              push_lo_stage_d = 32'h0;
            end
          end
          OFF_POP_LO: begin
            if (csr_req_write) begin
              flt = 1'b1;
            end else if (empty) begin
              flt   = 1'b1;
              unf_d = 1'b1;
            end else begin
              rd             = tos[31:0];
              pop_hi_latch_d = tos[63:32];
              top_d          = top_q - AW'(1);
              depth_d        = depth_q - DW'(1);
            end
          end
          OFF_POP_HI: begin
            if (csr_req_write) flt = 1'b1;
            else rd = pop_hi_latch_q;
          end
`ifdef FPU8097_STACK_PEEK_EN
          OFF_PEEK_LO: begin
            if (csr_req_write || empty) flt = 1'b1;
            else rd = tos[31:0];
          end
          OFF_PEEK_HI: begin
            if (csr_req_write || empty) flt = 1'b1;
            else rd = tos[63:32];
          end
`endif
          default: flt = 1'b1;
        endcase
      end
      rsp_fault_d = flt;
      rsp_rdata_d = flt ? 32'h0 : rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_INIT;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'h0;
      rsp_fault_q     <= 1'b0;
      eng_ack_q       <= 1'b0;
      depth_q         <= '0;
      top_q           <= '0;
      pop_hi_latch_q  <= 32'h0;
      push_lo_stage_q <= 32'h0;
      ovf_q           <= 1'b0;
      unf_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_fault_q     <= rsp_fault_d;
      eng_ack_q       <= eng_ack_d;
      depth_q         <= depth_d;
      top_q           <= top_d;
      pop_hi_latch_q  <= pop_hi_latch_d;
      push_lo_stage_q <= push_lo_stage_d;
      ovf_q           <= ovf_d;
      unf_q           <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end
endmodule

// File: doc/fpu_8097_csr_stack_responder.md
Name: fpu_8097_csr_stack_responder

Overview:
- CSR-side responder for the 8097 x87-style register stack. It decodes CSR reads and writes from a CSR initiator (core or bench driver) for STATUS, PUSH_LO/HI and POP_LO/HI, and returns data or a fault.
- Owns the 64-bit operand stack and exposes TOS/NOS to the arithmetic engine.
- Accepts engine pop/push updates, with engine priority over CSR traffic.

Parameters:
- DEPTH, 8, stack entries (power of two, 2..16).
- BASE_ADDR, 12'h000, CSR window base; word offsets STATUS=0x0, PUSH_LO=0x4, PUSH_HI=0x8, POP_LO=0xC, POP_HI=0x10, PEEK_LO=0x14, PEEK_HI=0x18.
- PRIV_MIN, 2'd0, minimum privilege accepted.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- csr_req_valid  in  1  request valid
- csr_req_ready  out  1  request accepted when valid&ready
- csr_req_write  in  1  1=write, 0=read
- csr_req_addr  in  12  CSR address
- csr_req_wdata  in  32  write data
- csr_req_wstrb  in  4  byte strobes
- csr_req_priv  in  2  requester privilege
- csr_rsp_valid  out  1  one-cycle response pulse
- csr_rsp_rdata  out  32  read data (0 on writes/faults)
- csr_rsp_fault  out  1  access fault
- busy_i  in  1  engine busy, reflected in STATUS[0]
- eng_valid  in  1  engine stack update
- eng_pop  in  2  entries to pop (0..2)
- eng_push  in  1  push eng_data after pops
- eng_data  in  64  result value
- eng_ack  out  1  update applied
- tos_o  out  64  top of stack (0 if empty)
- nos_o  out  64  next on stack (0 if depth<2)
- depth_o  out  $clog2(DEPTH)+1  entry count

Behaviour:
- Reset state:
  - Depth 0; staging regs pop_hi_latch and push_lo_stage cleared.
  - Sticky ovf/unf flags cleared.
  - csr_rsp_valid=0, csr_rsp_rdata=0, csr_rsp_fault=0, eng_ack=0, csr_req_ready=0.
  - Stack contents are don't-care.
- FSM IDLE/RESP:
  - IDLE: csr_req_ready=~eng_valid. On handshake, latch the result and go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, ready=0, then back to IDLE.
  - Latency is request handshake to response = 1 cycle; max one outstanding request.
- Engine priority:
  - When eng_valid=1, apply the update that cycle (eng_ack=1, registered pulse next cycle) and hold csr_req_ready=0.
  - If pop count > depth: depth=0, push still applied, unf set.
  - If push with depth==DEPTH after pops: value dropped, ovf set.
- Fault conditions (fault=1, rdata=0, no state change):
  - priv<PRIV_MIN.
  - Address outside the window, or unmapped offset.
  - Write to POP_*, or read of PUSH_*.
  - PUSH_* with wstrb!=4'hF.
- PUSH_LO: sets push_lo_stage=wdata.
- PUSH_HI:
  - If full: fault and set ovf.
  - Otherwise push {wdata, push_lo_stage}, then clear push_lo_stage.
- POP_LO:
  - If empty: fault and set unf.
  - Otherwise return TOS[31:0], set pop_hi_latch=TOS[63:32], depth-1.
- POP_HI: return pop_hi_latch; no stack change. Reading it repeatedly returns the same value.
- STATUS read layout:
  - [0]=busy_i
  - [8:4]=depth
  - [9]=full
  - [10]=empty
  - [11]=ovf
  - [12]=unf
  - others 0
- STATUS write: W1C on bits 11 and 12 (honours wstrb[1]); other bits ignored; no fault.
- Stack is circular with a top pointer; wrap modulo DEPTH. Depth is never > DEPTH and never < 0.
- Reset asserted mid-transaction: the response is aborted, no rsp_valid pulse is produced, and the state is cleared.

Optional Feature:
- Macro FPU8097_STACK_PEEK_EN.
- When defined: PEEK_LO/PEEK_HI reads return TOS[31:0]/TOS[63:32] with no stack change. An empty stack gives fault with no unf set.
- When undefined: those offsets are unmapped and fault.

Test Plan:
- Push 1.0 and 2.0 (LO=0, HI=0x3FF00000, then LO=0, HI=0x40000000) -> depth_o=2, tos_o=0x4000000000000000, nos_o=0x3FF0000000000000, STATUS[8:4]=2.
- Engine eng_pop=2, eng_push=1, eng_data=0x4008000000000000 while a CSR read is pending:
  - Expected: CSR stalled one cycle, eng_ack pulses, depth=1.
  - POP_LO->0, POP_HI->0x40080000, then STATUS empty=1.
- POP_LO on empty stack -> fault=1, rdata=0, STATUS[12]=1. STATUS write 0x1000 -> STATUS[12]=0.
- Push DEPTH+1 values -> last PUSH_HI fault, STATUS[9]=1 and [11]=1, tos unchanged.
- PUSH_LO with wstrb=4'h3, write at priv<PRIV_MIN (with PRIV_MIN=1), and read of address BASE+0x40 -> each faults, with no change to state.
- Assert rst during the RESP cycle -> no rsp_valid, all outputs 0 next cycle, depth 0. Then with PEEK_EN: push 4.0 and read PEEK_HI -> 0x40100000, depth still 1.
